// File: rtl/datamem_pkg.sv
// Shared types for the handshaked data memory: access-size and FSM state encodings.
package datamem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_BAD  = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/datamem_lane_align.sv
// Combinational lane steering: store byte enables and data placement, load
// extraction and extension, plus the size/alignment legality flags.
module datamem_lane_align
    import datamem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw,
    input  logic        is_unsigned,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        misaligned,
    output logic        bad_size
);

    size_t       sz;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign sz       = size_t'(size);
    assign byte_sel = raw[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be         = 4'b0000;
        wdata_sh   = 32'h0;
        rdata_ext  = 32'h0;
        misaligned = 1'b0;
        bad_size   = 1'b0;
        case (sz)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h0, byte_sel}
                                        : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_sh   = {2{wdata[15:0]}};
                rdata_ext  = is_unsigned ? {16'h0, half_sel}
                                         : {{16{half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                misaligned = (addr_lo != 2'b00);
                be         = 4'b1111;
                wdata_sh   = wdata;
                rdata_ext  = raw;
            end
            default: begin
                bad_size = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/datamem_hs.sv
// Byte-addressable little-endian data RAM with a valid/ready request port,
// configurable wait states and a one-cycle response pulse with an error flag.
module datamem_hs
    import datamem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE outside reset, and exactly one rsp_valid pulse
    // follows each accepted request unless reset intervenes first.

    localparam int              IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1)
                                                              : '0;

    logic [31:0]       mem [DEPTH_WORDS];

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;

    logic              accept;
    logic [ADDR_W-1:0] word_addr;
    logic              out_of_range;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       raw_word;
    logic              access_err;

    logic [3:0]        be;
    logic [31:0]       wdata_sh;
    logic [31:0]       rdata_ext;
    logic              misaligned;
    logic              bad_size;

    assign word_addr    = req_addr >> 2;
    assign out_of_range = (word_addr >= ADDR_W'(DEPTH_WORDS));
    assign idx          = req_addr[IDX_W+1:2];
    assign raw_word     = out_of_range ? 32'h0 : mem[idx];
    assign access_err   = bad_size | misaligned | out_of_range;
    assign accept       = req_valid & req_ready;
    assign dbg_state    = state;

    datamem_lane_align u_align (
        .size        (req_size),
        .addr_lo     (req_addr[1:0]),
        .wdata       (req_wdata),
        .raw         (raw_word),
        .is_unsigned (req_unsigned),
        .be          (be),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned),
        .bad_size    (bad_size)
    );

    // RAM holds its contents across reset; stores commit at the accept edge.
    always_ff @(posedge clk) begin
        if (accept && req_we && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        req_ready = (state == S_IDLE) && !reset;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_nx = S_RESP;
                    end else begin
                        state_nx = S_WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nx = S_RESP;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Response data is captured at accept and held; rsp_valid pulses on leaving RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rsp_valid <= (state == S_RESP);
            if (accept) begin
                rsp_err   <= access_err;
                rsp_rdata <= (access_err || req_we) ? 32'h0 : rdata_ext;
            end
        end
    end

endmodule

// File: doc/datamem_hs.md
Name: datamem_hs

Overview:
- Parametrised successor to the single-cycle data memory.
- Byte-addressable, little-endian data RAM for the CPU load/store stage.
- Supports byte/half/word stores through per-lane write enables, and sign- or zero-extended loads.
- Uses a valid/ready request and response handshake with configurable wait states, and flags misaligned, out-of-range and illegal-size accesses instead of corrupting memory.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words in the array.
- ADDR_W, 32, width of the byte address port.
- WAIT_STATES, 0, extra cycles between accept and response (legal range 0..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  access rejected; qualified by rsp_valid.

Behaviour:
- Reset:
  - All registers clear on a clk edge where reset=1.
  - After reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM in IDLE.
  - req_ready=0 while reset=1.
  - RAM contents are not cleared by reset.
- FSM states IDLE, WAIT, RESP:
  - req_ready = (state==IDLE) && !reset.
- Accept: req_valid && req_ready at edge t.
  - Next state is RESP if WAIT_STATES==0, else WAIT with the counter loaded to WAIT_STATES-1.
  - WAIT: counter decrements each edge; at 0, next state is RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then back to IDLE.
  - Latency: rsp_valid is high in the cycle after edge t+1+WAIT_STATES.
  - Back-to-back requests: next accept no earlier than the cycle rsp_valid falls. Throughput is one access per 2+WAIT_STATES cycles.
- Request capture: all request fields and the load result are captured at the accept edge.
  - Stores commit to RAM at the accept edge.
  - A load reads the RAM contents as they stand before that edge.
  - rsp_rdata and rsp_err hold the captured values until the next accept.
- Error checks, priority order:
  - size==3 is illegal.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Out-of-range: (req_addr>>2) >= DEPTH_WORDS, checked across the full ADDR_W.
  - On any error: no RAM write, rsp_err=1, rsp_rdata=0. The response still pulses after the normal latency.
- Store lanes, word index = addr>>2:
  - byte: lane addr[1:0] <= wdata[7:0].
  - half: lanes {2*addr[1]+1, 2*addr[1]} <= wdata[15:0].
  - word: all four lanes.
  - Unselected lanes are unchanged.
- Load:
  - Extract the same lane(s); lane 0 is bits [7:0].
  - Extend to 32 bits per req_unsigned. A word load ignores req_unsigned.
  - Store responses carry rsp_rdata=0, rsp_err=0.
- Inputs are ignored outside IDLE. A req_valid held high while busy is accepted only when back in IDLE.
- Reset mid-operation (in WAIT or RESP):
  - FSM returns to IDLE and the pending response is dropped; rsp_valid stays 0.
  - An already-committed store remains in RAM.

Decomposition:
- Package datamem_pkg:
  - size_t enum: SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2, SZ_BAD=2'd3.
  - state_t enum: S_IDLE, S_WAIT, S_RESP.
- Sub-module datamem_lane_align, combinational:
  - Produces the 4-bit lane write-enable and shifted write data from size/addr/wdata.
  - Produces the extended load result from the raw word, size, addr and unsigned flag.
  - Also drives the misaligned and illegal-size flags.
- Top level holds the RAM array, the FSM, the wait counter and the response registers.

Test Plan:
- WAIT_STATES=0: store word 0xDEADBEEF @0x10, then load word @0x10 -> each rsp_valid 2 cycles after its accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- After the above: store byte 0x5A @0x11; load byte signed @0x13 -> 0xFFFFFFDE; load half unsigned @0x10 -> 0x00005AEF; load word @0x10 -> 0xDEAD5AEF.
- Misaligned: load half @0x11 and store word @0x12 -> rsp_err=1, rsp_rdata=0; a following word load @0x10 is unchanged.
- Out-of-range with DEPTH_WORDS=128: store word @0x200 -> rsp_err=1; size=3 @0x0 -> rsp_err=1.
- WAIT_STATES=3 with req_valid held high: rsp_valid 5 cycles after each accept; req_ready low for 4 cycles after each accept; no request lost or duplicated.
- Reset asserted in a WAIT cycle after a store of 0x12345678 @0x20 -> no rsp_valid; after reset a word load @0x20 returns 0x12345678.
